exp_series_ctrl: RTL and testbench

//  Sequencer that evaluates e^x as a truncated Taylor series using the reciprocal ROM (entry n ~ 1/(n+1), Q0.8 in data[7:0]).

---
 rtl/exp_series_pkg.sv | 28 ++
 rtl/exp_mul_q16.sv | 18 +
 rtl/exp_series_ctrl.sv | 136 +++++++++++++
 tb/tb_exp_series_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/exp_series_pkg.sv
// rtl/exp_series_pkg.sv - shared types and constants for the e^x Taylor-series sequencer
package exp_series_pkg;

    // Operand/result width of the datapath
    localparam int X_W = 16;

    // Depth of the reciprocal ROM; bounds the legal number of series terms
    localparam int ROM_DEPTH = 12;

    // 1.0 in unsigned Q2.14
    localparam logic [15:0] ONE = 16'h4000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_X = 3'd1,
        MUL_R = 3'd2,
        ACC   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Unsigned add that clamps at all-ones instead of wrapping
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/exp_mul_q16.sv
// rtl/exp_mul_q16.sv - unsigned 16x16 multiply returning the upper half of the product
module exp_mul_q16
    import exp_series_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] p_hi
);

    logic [31:0] prod;

    // Full-width product, truncated to the upper 16 bits (fixed-point rescale)
    always_comb begin
        prod = {16'h0000, a} * {16'h0000, b};
        p_hi = prod[31:16];
    end

endmodule

// File: rtl/exp_series_ctrl.sv
// rtl/exp_series_ctrl.sv - sequencer evaluating e^x as a truncated Taylor series via a reciprocal ROM
module exp_series_ctrl
    import exp_series_pkg::*;
#(
    parameter int TERMS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] x_in,
    output logic        ready,
    output logic        done,
    output logic [15:0] result,
    output logic [3:0]  rom_addr,
    input  logic [15:0] rom_data
);

    if ((TERMS < 1) || (TERMS > ROM_DEPTH)) begin : g_bad_terms
        $error("exp_series_ctrl: TERMS must be within 1..ROM_DEPTH");
    end

    if (X_W != 16) begin : g_bad_width
        $error("exp_series_ctrl: only a 16-bit datapath is supported");
    end

    localparam logic [3:0] LAST_CNT = 4'(TERMS - 1);

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] x_r_q, x_r_d;
    logic [15:0] term_q, term_d;
    logic [15:0] acc_q, acc_d;

    logic [15:0] mul_b;
    logic [15:0] mul_p;

    // The ROM high byte carries nothing we use
    logic unused_rom_hi;
    assign unused_rom_hi = ^rom_data[15:8];

    // Operand B selects x in MUL_X and the scaled reciprocal 1/(n+1) in MUL_R
    always_comb begin
        mul_b = x_r_q;
        if (state_q == MUL_R) begin
            mul_b = {rom_data[7:0], 8'h00};
        end
    end

    exp_mul_q16 u_mul (
        .a    (term_q),
        .b    (mul_b),
        .p_hi (mul_p)
    );

    // Next-state logic: one term costs MUL_X, MUL_R, ACC; DONE publishes the sum
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        x_r_d    = x_r_q;
        term_d   = term_q;
        acc_d    = acc_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_r_d   = x_in;
                    term_d  = ONE;
                    acc_d   = ONE;
                    cnt_d   = 4'd0;
                    state_d = MUL_X;
                end
            end
            MUL_X: begin
                term_d  = mul_p;
                state_d = MUL_R;
            end
            MUL_R: begin
                term_d  = mul_p;
                state_d = ACC;
            end
            ACC: begin
                acc_d = sat_add16(acc_q, term_q);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = MUL_X;
                end
            end
            DONE: begin
                result_d = acc_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and datapath registers; reset discards any run in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= 16'h0000;
            cnt_q    <= 4'd0;
            x_r_q    <= 16'h0000;
            term_q   <= 16'h0000;
            acc_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            x_r_q    <= x_r_d;
            term_q   <= term_d;
            acc_q    <= acc_d;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign result   = result_q;
    assign rom_addr = cnt_q;

endmodule

// File: tb/tb_exp_series_ctrl.sv
// tb/tb_exp_series_ctrl.sv - self-checking bench for exp_series_ctrl with a scoreboard queue
module tb_exp_series_ctrl;

    localparam int TERMS   = 8;
    localparam int LATENCY = 3 * TERMS + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] x_in = 16'h0000;
    logic        ready;
    logic        done;
    logic [15:0] result;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    // Reciprocal ROM: entry n ~ 1/(n+1) in Q0.8, entry 0 clipped to 0xFF
    function automatic logic [7:0] recip(input logic [3:0] n);
        if (n == 4'd0) return 8'hFF;
        return 8'(256 / (int'(n) + 1));
    endfunction

    // Upper byte is junk so the bench notices if it leaks into the math
    always_comb rom_data = {8'hA5, recip(rom_addr)};

    // Golden truncating series model
    function automatic logic [15:0] model(input logic [15:0] x);
        logic [63:0] t;
        logic [63:0] a;
        t = 64'h4000;
        a = 64'h4000;
        for (int k = 0; k < TERMS; k++) begin
            t = (t * {48'h0, x}) >> 16;
            t = (t * {48'h0, recip(4'(k)), 8'h00}) >> 16;
            a = a + t;
            if (a > 64'hFFFF) a = 64'hFFFF;
        end
        return a[15:0];
    endfunction

    exp_series_ctrl #(.TERMS(TERMS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .x_in     (x_in),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    // Drive a one-cycle start and push the expected result
    task automatic accept(input logic [15:0] x);
        @(negedge clk);
        x_in  = x;
        start = 1'b1;
        exp_q.push_back(model(x));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done; pop the expected value when it arrives
    task automatic wait_done(output int cyc, output bit seen, output logic [15:0] exp);
        cyc  = 0;
        seen = 1'b0;
        exp  = 16'hxxxx;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (seen && exp_q.size() > 0) exp = exp_q.pop_front();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result got %h want 0000", result); end
        n_tests++; if (rom_addr !== 4'd0) begin n_fail++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        int cyc; bit seen; logic [15:0] exp;
        accept(16'h0000);
        wait_done(cyc, seen, exp);
        n_tests++; if (!seen || cyc != LATENCY) begin n_fail++; $display("FAIL zero_latency got %0d (seen=%0b) want %0d", cyc, seen, LATENCY); end
        n_tests++; if (result !== exp) begin n_fail++; $display("FAIL zero_model got %h want %h", result, exp); end
        n_tests++; if (result !== 16'h4000) begin n_fail++; $display("FAIL zero_one got %h want 4000", result); end
        @(posedge clk); #1;
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse got %b want 0", done); end
        n_tests++; if (result !== 16'h4000) begin n_fail++; $display("FAIL zero_hold got %h want 4000", result); end
    endtask

    task automatic test_half();
        int cyc; bit seen; logic [15:0] exp;
        accept(16'h8000);
        wait_done(cyc, seen, exp);
        n_tests++; if (!seen || result !== exp) begin n_fail++; $display("FAIL half_model got %h want %h", result, exp); end
        n_tests++; if (result < 16'h6900 || result > 16'h6990) begin n_fail++; $display("FAIL half_range got %h want 6900..6990", result); end
    endtask

    task automatic test_max();
        logic [15:0] exp;
        bit seen;
        accept(16'hFFFF);
        n_tests++; if (rom_addr !== 4'd0) begin n_fail++; $display("FAIL max_addr0 got %0d want 0", rom_addr); end
        seen = 1'b0;
        for (int c = 1; c < 200; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin seen = 1'b1; break; end
            if (c <= 3 * TERMS - 1) begin
                n_tests++;
                if (rom_addr !== 4'(c / 3)) begin n_fail++; $display("FAIL max_addr_c%0d got %0d want %0d", c, rom_addr, c / 3); end
            end
        end
        exp = (seen && exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        n_tests++; if (!seen || result !== exp) begin n_fail++; $display("FAIL max_model got %h want %h", result, exp); end
        n_tests++; if (result >= 16'hB000) begin n_fail++; $display("FAIL max_bound got %h want < b000", result); end
    endtask

    task automatic test_ignore();
        int cyc; bit seen; logic [15:0] exp; logic [15:0] prev; bit extra;
        prev = result;
        accept(16'h8000);
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_ready got %b want 0", ready); end
        x_in  = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++; if (result !== prev) begin n_fail++; $display("FAIL ignore_result_hold got %h want %h", result, prev); end
        wait_done(cyc, seen, exp);
        n_tests++; if (!seen || result !== exp) begin n_fail++; $display("FAIL ignore_model got %h want %h", result, exp); end
        extra = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra = 1'b1;
        end
        n_tests++; if (extra) begin n_fail++; $display("FAIL ignore_queued got extra done want none"); end
    endtask

    task automatic test_back_to_back();
        int cyc; bit seen; logic [15:0] exp;
        @(negedge clk);
        x_in  = 16'h4000;
        start = 1'b1;
        exp_q.push_back(model(16'h4000));
        @(posedge clk); #1;
        wait_done(cyc, seen, exp);
        n_tests++; if (!seen || result !== exp) begin n_fail++; $display("FAIL b2b_first got %h want %h", result, exp); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", ready); end
        @(negedge clk);
        x_in = 16'h2000;
        exp_q.push_back(model(16'h2000));
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc, seen, exp);
        n_tests++; if (!seen || cyc != LATENCY) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", cyc, LATENCY); end
        n_tests++; if (result !== exp) begin n_fail++; $display("FAIL b2b_second got %h want %h", result, exp); end
    endtask

    task automatic test_reset_midrun();
        int cyc; bit seen; logic [15:0] exp; bit any_done;
        accept(16'hC000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++; if (ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl got ready=%b done=%b want 1/0", ready, done); end
        n_tests++; if (result !== 16'h0000) begin n_fail++; $display("FAIL midrst_result got %h want 0000", result); end
        n_tests++; if (rom_addr !== 4'd0) begin n_fail++; $display("FAIL midrst_addr got %0d want 0", rom_addr); end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        any_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) any_done = 1'b1;
        end
        n_tests++; if (any_done) begin n_fail++; $display("FAIL midrst_no_done got done want none"); end
        accept(16'h6000);
        wait_done(cyc, seen, exp);
        n_tests++; if (!seen || cyc != LATENCY) begin n_fail++; $display("FAIL midrst_latency got %0d want %0d", cyc, LATENCY); end
        n_tests++; if (result !== exp) begin n_fail++; $display("FAIL midrst_result2 got %h want %h", result, exp); end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_half();
        test_max();
        test_ignore();
        test_back_to_back();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
